add128_pipe: RTL and testbench
==============================

ADD128_PIPE -- requirements
Module: add128_pipe

Interface
REQ-001 Parameter N, 128, operand and sum width; SHALL be even and at least 8.
REQ-002 Parameter H, N/2, width of each pipeline half; derived, SHALL NOT be overridden.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  input  1  operand beat offered.
REQ-006 in_ready  output  1  block accepts the operand beat this cycle.
REQ-007 cin  input  1  carry-in of the beat.
REQ-008 a  input  N  operand A.
REQ-009 b  input  N  operand B.
REQ-010 out_valid  output  1  result beat presented.
REQ-011 out_ready  input  1  consumer accepts the result beat.
REQ-012 s  output  N  registered sum a+b+cin, modulo 2^N.
REQ-013 cout  output  1  registered carry-out of bit N-1.
REQ-014 ovf  output  1  signed overflow; present only with ADD128_PIPE_OVF_EN.

Function
REQ-015 Transfer in SHALL occur when in_valid & in_ready; transfer out SHALL occur when out_valid & out_ready.
REQ-016 Stage 1, on transfer in, SHALL register s_lo = a[H-1:0]+b[H-1:0]+cin, c_mid = its carry-out, a[N-1:H], b[N-1:H], and set v1.
REQ-017 Stage 2, on advance from stage 1, SHALL register s = {a_hi+b_hi+c_mid, s_lo}, cout = carry-out of that upper add, and set v2.
REQ-018 out_valid SHALL equal v2; s, cout, ovf SHALL be driven directly from stage-2 registers, with no combinational path from inputs.
REQ-019 Stage 2 SHALL accept stage 1 when !v2 | out_ready (adv2); in_ready SHALL equal !v1 | adv2.
REQ-020 Latency SHALL be 2 cycles, transfer-in edge to out_valid high, with out_ready held high.
REQ-021 Throughput SHALL be one beat per cycle while out_ready is high.
REQ-022 With out_ready low and both stages full, in_ready SHALL be 0; held beats and outputs SHALL NOT change.
REQ-023 Simultaneous transfer out and stage-1 advance SHALL replace the stage-2 beat in the same cycle, with no bubble.
REQ-024 Stage 1 with v1=0 and no transfer in SHALL clear nothing but v1; data registers MAY hold stale values.
REQ-025 Beat ordering SHALL be preserved; no beat SHALL be dropped or duplicated.
REQ-026 Stage-1 hold SHALL keep c_mid; carry from a stale beat SHALL never reach a newer beat.
REQ-027 Sum arithmetic SHALL be unsigned modulo 2^N; all-ones + 0 + cin=1 SHALL wrap to 0 with cout=1.

Reset
REQ-028 rst_n low SHALL immediately clear v1, v2, s, cout, ovf, s_lo, c_mid, and the hi operand registers to 0.
REQ-029 During reset, out_valid=0 and in_ready=1 SHALL hold once v1=0.
REQ-030 Reset mid-operation SHALL discard all in-flight beats; no beat SHALL emerge after release.
REQ-031 Deassertion SHALL be synchronised externally; the first transfer in SHALL be possible on the first edge after release.

Configuration
REQ-032 Macro ADD128_PIPE_OVF_EN defined: port ovf SHALL exist, registered in stage 2 as (a[N-1]==b[N-1]) & (s[N-1]!=a[N-1]) using the staged operand MSBs, and reset to 0.
REQ-033 Macro ADD128_PIPE_OVF_EN undefined: port ovf and its register SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-034 A shared package add_pkg SHALL hold ADD_N=128, ADD_H=64, and the typedef for the stage-1 record (s_lo, c_mid, a_hi, b_hi).
REQ-035 One sub-module, add_half, SHALL provide an H-bit adder with cin, s, cout, instantiated once per stage.
REQ-036 add_half SHALL be purely combinational; all registers SHALL reside in add128_pipe.

Verification
REQ-037 a=2^64-1, b=1, cin=0, out_ready=1 -> after 2 cycles s=2^64, cout=0: cross-half carry correct.
REQ-038 a=2^128-1, b=0, cin=1 -> s=0, cout=1; with OVF_EN, ovf=0.
REQ-039 With OVF_EN, a=2^127-1, b=1, cin=0 -> s=2^127, cout=0, ovf=1.
REQ-040 Beats 1..8 of random operands, out_ready low for cycles 3-6 -> in_ready=0 while full; beats out in order, values equal to the reference sum, none lost.
REQ-041 Beats streamed back-to-back with out_ready=1 -> one result per cycle from cycle 2; no bubbles.
REQ-042 rst_n pulsed low with both stages full -> out_valid=0 immediately, s=0; no beat emerges after release until a new transfer in.

Source files
------------

// File: rtl/add_pkg.sv
// Shared constants and the stage-1 record layout for the two-stage 128-bit adder.
package add_pkg;

  localparam int ADD_N = 128;
  localparam int ADD_H = ADD_N / 2;

  typedef struct packed {
    logic [ADD_H-1:0] s_lo;
    logic             c_mid;
    logic [ADD_H-1:0] a_hi;
    logic [ADD_H-1:0] b_hi;
  } stg1_rec_t;

endpackage

// File: rtl/add_half.sv
// Purely combinational W-bit adder with carry-in and carry-out; one instance per pipeline stage.
module add_half
  import add_pkg::*;
#(
  parameter int W = ADD_H
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout
);

  logic [W:0] sum;

  assign sum  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
  assign s    = sum[W-1:0];
  assign cout = sum[W];

endmodule

// File: rtl/add128_pipe.sv
// Two-stage valid/ready pipelined N-bit adder: low half in stage 1, high half in stage 2.
// Optional signed-overflow output enabled by defining ADD128_PIPE_OVF_EN.
module add128_pipe
  import add_pkg::*;
#(
  parameter int N = ADD_N
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         cin,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] s,
  output logic         cout
`ifdef ADD128_PIPE_OVF_EN
  ,
  output logic         ovf
`endif
);

  localparam int H = N / 2;

  if ((N % 2) != 0 || N < 8) begin : g_bad_width
    $error("add128_pipe: N must be even and at least 8");
  end

  typedef struct packed {
    logic [H-1:0] s_lo;
    logic         c_mid;
    logic [H-1:0] a_hi;
    logic [H-1:0] b_hi;
  } stg1_t;

`ifdef ADD128_PIPE_OVF_EN
  // Two's-complement overflow: equal operand signs but a result sign that differs.
  function automatic logic ovf_detect(input logic signed [H-1:0] a_hi_s,
                                      input logic signed [H-1:0] b_hi_s,
                                      input logic signed [H-1:0] s_hi_s);
    return (a_hi_s[H-1] == b_hi_s[H-1]) && (s_hi_s[H-1] != a_hi_s[H-1]);
  endfunction
`endif

  stg1_t        stg1_p1;
  logic         vld_p1;
  logic         vld_p2;
  logic [N-1:0] s_p2;
  logic         cout_p2;

  logic         adv2;
  logic         xfer_in;
  logic [H-1:0] s_lo_p0;
  logic         c_mid_p0;
  logic [H-1:0] s_hi_p1;
  logic         cout_p1;

  assign adv2     = !vld_p2 || out_ready;
  assign in_ready = !vld_p1 || adv2;
  assign xfer_in  = in_valid && in_ready;

  // Stage 0 -> 1: low half added straight from the inputs.
  add_half #(.W(H)) u_lo (
    .a    (a[H-1:0]),
    .b    (b[H-1:0]),
    .cin  (cin),
    .s    (s_lo_p0),
    .cout (c_mid_p0)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      stg1_p1 <= '0;
    end else if (xfer_in) begin
      vld_p1        <= 1'b1;
      stg1_p1.s_lo  <= s_lo_p0;
      stg1_p1.c_mid <= c_mid_p0;
      stg1_p1.a_hi  <= a[N-1:H];
      stg1_p1.b_hi  <= b[N-1:H];
    end else if (adv2) begin
      vld_p1 <= 1'b0;
    end
  end

  // Stage 1 -> 2: high half consumes the carry held alongside its own beat.
  add_half #(.W(H)) u_hi (
    .a    (stg1_p1.a_hi),
    .b    (stg1_p1.b_hi),
    .cin  (stg1_p1.c_mid),
    .s    (s_hi_p1),
    .cout (cout_p1)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p2  <= 1'b0;
      s_p2    <= '0;
      cout_p2 <= 1'b0;
    end else if (adv2) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        s_p2    <= {s_hi_p1, stg1_p1.s_lo};
        cout_p2 <= cout_p1;
      end
    end
  end

`ifdef ADD128_PIPE_OVF_EN
  logic ovf_p2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_p2 <= 1'b0;
    end else if (adv2 && vld_p1) begin
      ovf_p2 <= ovf_detect(stg1_p1.a_hi, stg1_p1.b_hi, s_hi_p1);
    end
  end

  assign ovf = ovf_p2;
`endif

  assign out_valid = vld_p2;
  assign s         = s_p2;
  assign cout      = cout_p2;

endmodule

// File: tb/tb_add128_pipe.sv
// Scoreboard bench for add128_pipe: directed vectors, stall, streaming and mid-flight reset.
module tb_add128_pipe;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic         cin;
  logic [127:0] a;
  logic [127:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] s;
  logic         cout;
`ifdef ADD128_PIPE_OVF_EN
  logic         ovf;
`endif

  add128_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .cin       (cin),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .cout      (cout)
`ifdef ADD128_PIPE_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  typedef struct {
    logic [127:0] s;
    logic         cout;
    logic         ovf;
  } exp_t;

  exp_t         exp_q[$];
  exp_t         mon_e;
  int           out_cyc_q[$];
  int           errors;
  int           checks;
  int           cyc;

  logic [127:0] va[9];
  logic [127:0] vb[9];
  logic         vcin[9];
  logic [127:0] vs[9];
  logic         vcout[9];
  logic         vovf[9];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: every accepted result beat is compared against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      out_cyc_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: got s=%h with no beat outstanding", s);
      end else begin
        mon_e = exp_q.pop_front();
        chk("sum", s, mon_e.s);
        chk("cout", {127'd0, cout}, {127'd0, mon_e.cout});
`ifdef ADD128_PIPE_OVF_EN
        chk("ovf", {127'd0, ovf}, {127'd0, mon_e.ovf});
`endif
      end
    end
  end

  task automatic send(input int idx, output int acc_cyc);
    exp_t e;
    bit   ok;
    in_valid = 1'b1;
    a        = va[idx];
    b        = vb[idx];
    cin      = vcin[idx];
    ok       = 1'b0;
    acc_cyc  = -1;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: beat %0d got in_ready=0 expected 1 within 50 cycles", idx);
    end else begin
      acc_cyc = cyc;
      e.s     = vs[idx];
      e.cout  = vcout[idx];
      e.ovf   = vovf[idx];
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    bit done;
    done = 1'b0;
    for (int t = 0; t < 60; t++) begin
      @(posedge clk);
      if (exp_q.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    #1;
    chk("drain_remaining", 128'(exp_q.size()), 128'd0);
    if (!done) $display("FAIL drain_timeout: beats still outstanding after 60 cycles");
  endtask

  initial begin
    int     acc0;
    int     acc_dummy;
    logic [127:0] s_hold;

    errors = 0;
    checks = 0;

    // Hand-computed vectors: a, b, cin -> s, cout, ovf.
    va[0] = 128'h0;                                    vb[0] = 128'h0;                                    vcin[0] = 1'b0;
    vs[0] = 128'h0;                                    vcout[0] = 1'b0; vovf[0] = 1'b0;
    va[1] = 128'h0000000000000000_FFFFFFFFFFFFFFFF;    vb[1] = 128'h1;                                    vcin[1] = 1'b0;
    vs[1] = 128'h0000000000000001_0000000000000000;    vcout[1] = 1'b0; vovf[1] = 1'b0;
    va[2] = 128'hFFFFFFFFFFFFFFFF_FFFFFFFFFFFFFFFF;    vb[2] = 128'h0;                                    vcin[2] = 1'b1;
    vs[2] = 128'h0;                                    vcout[2] = 1'b1; vovf[2] = 1'b0;
    va[3] = 128'h7FFFFFFFFFFFFFFF_FFFFFFFFFFFFFFFF;    vb[3] = 128'h1;                                    vcin[3] = 1'b0;
    vs[3] = 128'h8000000000000000_0000000000000000;    vcout[3] = 1'b0; vovf[3] = 1'b1;
    va[4] = 128'h8000000000000000_0000000000000000;    vb[4] = 128'h8000000000000000_0000000000000000;    vcin[4] = 1'b0;
    vs[4] = 128'h0;                                    vcout[4] = 1'b1; vovf[4] = 1'b1;
    va[5] = 128'h0123456789ABCDEF_FEDCBA9876543210;    vb[5] = 128'h1111111111111111_1111111111111111;    vcin[5] = 1'b0;
    vs[5] = 128'h123456789ABCDF01_0FEDCBA987654321;    vcout[5] = 1'b0; vovf[5] = 1'b0;
    va[6] = 128'hFFFFFFFFFFFFFFFF_0000000000000000;    vb[6] = 128'h0000000000000001_0000000000000000;    vcin[6] = 1'b1;
    vs[6] = 128'h0000000000000000_0000000000000001;    vcout[6] = 1'b1; vovf[6] = 1'b0;
    va[7] = 128'h4000000000000000_0000000000000000;    vb[7] = 128'h4000000000000000_0000000000000000;    vcin[7] = 1'b0;
    vs[7] = 128'h8000000000000000_0000000000000000;    vcout[7] = 1'b0; vovf[7] = 1'b1;
    va[8] = 128'h0000000000000000_FFFFFFFFFFFFFFFF;    vb[8] = 128'h0000000000000000_FFFFFFFFFFFFFFFF;    vcin[8] = 1'b1;
    vs[8] = 128'h0000000000000001_FFFFFFFFFFFFFFFF;    vcout[8] = 1'b0; vovf[8] = 1'b0;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    cin       = 1'b0;
    a         = '0;
    b         = '0;
    out_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {127'd0, out_valid}, 128'd0);
    chk("rst_in_ready", {127'd0, in_ready}, 128'd1);
    chk("rst_s", s, 128'd0);
    chk("rst_cout", {127'd0, cout}, 128'd0);
`ifdef ADD128_PIPE_OVF_EN
    chk("rst_ovf", {127'd0, ovf}, 128'd0);
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Back-to-back stream with the consumer always ready.
    out_cyc_q.delete();
    send(0, acc0);
    for (int i = 1; i < 9; i++) send(i, acc_dummy);
    wait_drain();
    chk("stream_count", 128'(out_cyc_q.size()), 128'd9);
    if (out_cyc_q.size() == 9) begin
      chk("stream_latency", 128'(out_cyc_q[0] - acc0), 128'd2);
      chk("stream_no_bubble", 128'(out_cyc_q[8] - out_cyc_q[0]), 128'd8);
    end

    // Eight beats with the consumer stalled for four cycles mid-stream.
    fork
      begin
        for (int i = 0; i < 8; i++) send(i, acc_dummy);
      end
      begin
        repeat (2) @(posedge clk);
        #1;
        out_ready = 1'b0;
        s_hold    = '0;
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          if (k == 0) s_hold = s;
          else begin
            chk("stall_in_ready", {127'd0, in_ready}, 128'd0);
            chk("stall_out_valid", {127'd0, out_valid}, 128'd1);
            chk("stall_s_held", s, s_hold);
          end
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    wait_drain();

    // Fill both stages, then reset with beats in flight.
    out_ready = 1'b0;
    send(3, acc_dummy);
    send(4, acc_dummy);
    @(negedge clk);
    chk("full_in_ready", {127'd0, in_ready}, 128'd0);
    chk("full_out_valid", {127'd0, out_valid}, 128'd1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {127'd0, out_valid}, 128'd0);
    chk("midrst_s", s, 128'd0);
    chk("midrst_cout", {127'd0, cout}, 128'd0);
    chk("midrst_in_ready", {127'd0, in_ready}, 128'd1);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    repeat (5) @(negedge clk);
    chk("post_rst_idle", {127'd0, out_valid}, 128'd0);
    send(5, acc_dummy);
    wait_drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded 200000 time units");
    $fatal(1);
  end

endmodule
